// File: rtl/sum_stationary_drain.sv
// sum_stationary_drain
// Result-side receiver for the output-stationary N x N engine. Each valid_i pulse
// delivers a full N*N accumulator snapshot. Up to two snapshots are held in a
// ping-pong store and streamed out one row (N elements) per valid/ready beat.
// The engine cannot be stalled, so a snapshot that finds the store full is
// dropped and the loss is flagged on the sticky overflow_o.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset, clears state and both banks
//   valid_i      one-cycle pulse: c_i holds a complete snapshot
//   c_i          snapshot, c_i[r*N+k] = element (r, k)
//   row_valid_o  row_o / row_idx_o / last_o are valid
//   row_ready_i  downstream accepts the current row
//   row_o        current row of the head snapshot
//   row_idx_o    index of the current row
//   last_o       current row is the final row of its snapshot
//   count_o      snapshots held (0..2), including the one being drained
//   overflow_o   sticky: a snapshot was dropped
module sum_stationary_drain #(
  parameter int unsigned N            = 4,
  parameter int unsigned C_DATA_WIDTH = 18
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  input  logic [C_DATA_WIDTH-1:0]  c_i [N*N],
  output logic                     row_valid_o,
  input  logic                     row_ready_i,
  output logic [C_DATA_WIDTH-1:0]  row_o [N],
  output logic [$clog2(N)-1:0]     row_idx_o,
  output logic                     last_o,
  output logic [1:0]               count_o,
  output logic                     overflow_o
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned AddrW = $clog2(N*N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N-1);

  logic [C_DATA_WIDTH-1:0] bank_q [2][N*N];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [IdxW-1:0]         row_idx_q;
  logic [1:0]              count_q;
  logic [1:0]              count_d;
  logic                    overflow_q;

  logic row_valid;
  logic beat;
  logic pop;
  logic capture;

  always_comb begin
    row_valid = (count_q != 2'd0);
    beat      = row_valid && row_ready_i;
    pop       = beat && (row_idx_q == LastIdx);
    // A full store can still accept when the head snapshot retires this cycle.
    capture   = valid_i && ((count_q != 2'd2) || pop);

    count_d = count_q;
    unique case ({capture, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      row_idx_q  <= '0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N*N; i++) begin
          bank_q[b][AddrW'(i)] <= '0;
        end
      end
    end else begin
      if (capture) begin
        for (int i = 0; i < N*N; i++) begin
          bank_q[wr_ptr_q][AddrW'(i)] <= c_i[AddrW'(i)];
        end
        wr_ptr_q <= ~wr_ptr_q;
      end else if (valid_i) begin
        overflow_q <= 1'b1;
      end

      if (beat) begin
        if (pop) begin
          row_idx_q <= '0;
          rd_ptr_q  <= ~rd_ptr_q;
        end else begin
          row_idx_q <= row_idx_q + IdxW'(1);
        end
      end

      count_q <= count_d;
    end
  end

  // Row data is a pure mux off the registered head bank, so it holds while stalled.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      row_o[k] = bank_q[rd_ptr_q][AddrW'(int'(row_idx_q) * N + k)];
    end
  end

  assign row_valid_o = row_valid;
  assign row_idx_o   = row_idx_q;
  assign last_o      = row_valid && (row_idx_q == LastIdx);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_sum_stationary_drain.sv
// Self-checking bench for sum_stationary_drain. Expected rows are queued when a
// snapshot is driven and is expected to be accepted; a negedge monitor pops and
// compares on every handshake beat.
module tb_sum_stationary_drain;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 18;

  typedef struct {
    logic [127:0] data;
    int           idx;
    logic         last;
  } row_t;

  logic          clk;
  logic          reset;
  logic          valid;
  logic [CW-1:0] c [N*N];
  logic          row_valid;
  logic          row_ready;
  logic [CW-1:0] row [N];
  logic [1:0]    row_idx;
  logic          last;
  logic [1:0]    count;
  logic          overflow;

  int   n_checks = 0;
  int   n_fails  = 0;
  row_t exp_q[$];

  sum_stationary_drain #(
    .N            (N),
    .C_DATA_WIDTH (CW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .valid_i     (valid),
    .c_i         (c),
    .row_valid_o (row_valid),
    .row_ready_i (row_ready),
    .row_o       (row),
    .row_idx_o   (row_idx),
    .last_o      (last),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_row();
    logic [127:0] v = '0;
    for (int k = 0; k < N; k++) v[k*CW +: CW] = row[k];
    return v;
  endfunction

  function automatic logic [127:0] model_row(input int off, input int r);
    logic [127:0] v = '0;
    for (int k = 0; k < N; k++) v[k*CW +: CW] = CW'(off + r*N + k);
    return v;
  endfunction

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present snapshot c[k] = off + k for one cycle; queue its rows if it should land.
  task automatic send(input int off, input bit accept);
    valid = 1'b1;
    for (int i = 0; i < N*N; i++) c[i] = CW'(off + i);
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        row_t e;
        e.data = model_row(off, r);
        e.idx  = r;
        e.last = (r == N-1);
        exp_q.push_back(e);
      end
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: compare each accepted row against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && row_valid && row_ready) begin
      check_eq("row_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        row_t e;
        e = exp_q.pop_front();
        check_eq("row_data", pack_row(), e.data);
        check_eq("row_idx", row_idx, e.idx);
        check_eq("row_last", last, e.last);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    valid     = 1'b0;
    row_ready = 1'b0;
    for (int i = 0; i < N*N; i++) c[i] = '0;
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", row_valid, 0);
    check_eq("rst_idx", row_idx, 0);
    check_eq("rst_last", last, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_row", pack_row(), 0);

    // Single snapshot, ready high
    row_ready = 1'b1;
    send(1, 1'b1);
    check_eq("single_valid", row_valid, 1);
    check_eq("single_count", count, 1);
    for (int i = 0; i < N; i++) tick();
    check_eq("single_done_count", count, 0);
    check_eq("single_done_valid", row_valid, 0);
    check_eq("single_empty_q", exp_q.size(), 0);

    // Backpressure: head row holds while ready is low
    row_ready = 1'b0;
    send(1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_row", pack_row(), model_row(1, 0));
      check_eq("bp_idx", row_idx, 0);
      check_eq("bp_valid", row_valid, 1);
      tick();
    end
    row_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      check_eq("bp_stream_valid", row_valid, 1);
      tick();
    end
    check_eq("bp_done_count", count, 0);
    check_eq("bp_empty_q", exp_q.size(), 0);

    // Back-to-back snapshots stream with no bubble
    send(1, 1'b1);
    for (int i = 1; i <= 2*N; i++) begin
      check_eq("b2b_valid", row_valid, 1);
      check_eq("b2b_count", count, 1);
      if (i == N) send(101, 1'b1);
      else tick();
    end
    check_eq("b2b_done_count", count, 0);
    check_eq("b2b_empty_q", exp_q.size(), 0);

    // Overflow: third snapshot dropped while stalled
    row_ready = 1'b0;
    send(1, 1'b1);
    send(101, 1'b1);
    check_eq("ovf_pre", overflow, 0);
    send(201, 1'b0);
    check_eq("ovf_count", count, 2);
    check_eq("ovf_flag", overflow, 1);
    row_ready = 1'b1;
    for (int i = 0; i < 2*N; i++) tick();
    check_eq("ovf_drain_count", count, 0);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_empty_q", exp_q.size(), 0);

    // Full store with simultaneous pop accepts the new snapshot
    do_reset();
    check_eq("clr_ovf", overflow, 0);
    row_ready = 1'b0;
    send(1, 1'b1);
    send(101, 1'b1);
    row_ready = 1'b1;
    for (int i = 0; i < N-1; i++) tick();
    check_eq("full_idx", row_idx, N-1);
    check_eq("full_count", count, 2);
    send(201, 1'b1);
    check_eq("full_pop_count", count, 2);
    check_eq("full_pop_ovf", overflow, 0);
    for (int i = 0; i < 2*N; i++) tick();
    check_eq("full_drain_count", count, 0);
    check_eq("full_drain_ovf", overflow, 0);
    check_eq("full_empty_q", exp_q.size(), 0);

    // Reset mid-drain discards everything; valid_i during reset is ignored
    row_ready = 1'b0;
    send(1, 1'b1);
    send(101, 1'b1);
    row_ready = 1'b1;
    tick();
    tick();
    check_eq("mid_idx", row_idx, 2);
    check_eq("mid_count", count, 2);
    reset = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < N*N; i++) c[i] = CW'(201 + i);
    tick();
    reset = 1'b0;
    valid = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_valid", row_valid, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_idx", row_idx, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    check_eq("mid_rst_row", pack_row(), 0);
    tick();
    tick();
    check_eq("mid_rst_stays_empty", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
